tetris_cmd_arbiter: RTL and testbench

Command front-end for `tetris_2048_core`. It debounces the three raw push-buttons and runs a gravity (auto-drop) timer. It arbitrates user and timer requests into clean single-cycle `cmd_l` / `cmd_r` / `cmd_drop` pulses for the core. Commands are issued only while the core reports it is waiting for input, and a drop is held off until the core has finished the drop/spawn sequence.

---
 rtl/tetris_cmd_arbiter.sv | 186 ++++++++++++++++++
 tb/tb_tetris_cmd_arbiter.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/tetris_cmd_arbiter.sv
// Command front-end for tetris_2048_core: synchronizes and debounces the buttons,
// runs the gravity timer and turns requests into single-cycle command pulses.
module tetris_cmd_arbiter #(
  parameter int DB_CYCLES   = 1_000_000,
  parameter int DROP_CYCLES = 300_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_l_raw,
  input  logic btn_r_raw,
  input  logic btn_drop_raw,
  input  logic auto_en,
  input  logic core_ready,
  input  logic game_over,
  output logic cmd_l,
  output logic cmd_r,
  output logic cmd_drop,
  output logic drop_src,
  output logic busy
);

  localparam int DBW = $clog2(DB_CYCLES + 1);
  localparam int TW  = $clog2(DROP_CYCLES + 1);
  localparam logic [DBW-1:0] DB_LAST   = DBW'(DB_CYCLES - 1);
  localparam logic [TW-1:0]  DROP_LAST = TW'(DROP_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    GAP,
    WAIT_BUSY,
    WAIT_READY
  } state_t;

  state_t state;

  // Button vectors are ordered {drop, right, left}.
  logic [2:0]     raw;
  logic [2:0]     sync_p0;
  logic [2:0]     sync_p1;
  logic [2:0]     stable;
  logic [2:0]     stable_d;
  logic [2:0]     rise;
  logic [2:0]     pend;
  logic [2:0]     pend_clr;
  logic [DBW-1:0] db_cnt [3];

  logic           auto_pend;
  logic [TW-1:0]  timer;
  logic           timer_run;
  logic           timer_hit;

  logic           grant_user;
  logic           grant_auto;
  logic           grant_drop;
  logic           grant_l;
  logic           grant_r;

  assign raw = {btn_drop_raw, btn_r_raw, btn_l_raw};

  // Stage p0/p1: two-flop synchronizer, then per-button debounce
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_p0  <= '0;
      sync_p1  <= '0;
      stable   <= '0;
      stable_d <= '0;
      for (int i = 0; i < 3; i++) begin
        db_cnt[i] <= '0;
      end
    end else begin
      sync_p0  <= raw;
      sync_p1  <= sync_p0;
      stable_d <= stable;
      for (int i = 0; i < 3; i++) begin
        if (sync_p1[i] == stable[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          stable[i] <= sync_p1[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + DBW'(1);
        end
      end
    end
  end

  assign rise      = stable & ~stable_d;
  assign timer_run = auto_en & core_ready & ~game_over & (state == IDLE);
  assign timer_hit = timer_run & (timer == DROP_LAST);

  always_comb begin
    grant_user = 1'b0;
    grant_auto = 1'b0;
    grant_l    = 1'b0;
    grant_r    = 1'b0;
    if ((state == IDLE) && core_ready && !game_over) begin
      if (pend[2]) begin
        grant_user = 1'b1;
      end else if (auto_pend) begin
        grant_auto = 1'b1;
      end else if (pend[0]) begin
        grant_l = 1'b1;
      end else if (pend[1]) begin
        grant_r = 1'b1;
      end
    end
  end

  assign grant_drop = grant_user | grant_auto;
  // A drop discards every queued move; a move only retires its own flag.
  assign pend_clr   = grant_drop ? 3'b111 : {1'b0, grant_r, grant_l};

  // Stage p2: pending flags, gravity timer, arbitration FSM and output register
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      pend      <= '0;
      auto_pend <= 1'b0;
      timer     <= '0;
      cmd_l     <= 1'b0;
      cmd_r     <= 1'b0;
      cmd_drop  <= 1'b0;
      drop_src  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      cmd_l    <= 1'b0;
      cmd_r    <= 1'b0;
      cmd_drop <= 1'b0;
      if (game_over) begin
        state     <= IDLE;
        busy      <= 1'b0;
        pend      <= '0;
        auto_pend <= 1'b0;
        timer     <= '0;
      end else begin
        if (!timer_run || timer_hit || grant_drop) begin
          timer <= '0;
        end else begin
          timer <= timer + TW'(1);
        end
        // New edges are ORed in after the clear so a same-cycle set survives.
        pend      <= (pend & ~pend_clr) | rise;
        auto_pend <= (auto_pend & ~grant_drop) | timer_hit;

        case (state)
          IDLE: begin
            if (grant_drop) begin
              cmd_drop <= 1'b1;
              drop_src <= grant_auto;
              state    <= WAIT_BUSY;
              busy     <= 1'b1;
            end else if (grant_l) begin
              cmd_l <= 1'b1;
              state <= GAP;
              busy  <= 1'b1;
            end else if (grant_r) begin
              cmd_r <= 1'b1;
              state <= GAP;
              busy  <= 1'b1;
            end
          end
          GAP: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
          WAIT_BUSY: begin
            if (!core_ready) begin
              state <= WAIT_READY;
            end
          end
          WAIT_READY: begin
            if (core_ready) begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tetris_cmd_arbiter.sv
// Bench for tetris_cmd_arbiter: directed scenarios plus random stimulus, all
// compared each cycle against a behavioural model of the command rules.
module tb_tetris_cmd_arbiter;

  localparam int DB   = 4;
  localparam int DROP = 20;

  logic clk = 1'b0;
  logic rst;
  logic btn_l_raw, btn_r_raw, btn_drop_raw;
  logic auto_en, core_ready, game_over;
  logic cmd_l, cmd_r, cmd_drop, drop_src, busy;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  tetris_cmd_arbiter #(
    .DB_CYCLES  (DB),
    .DROP_CYCLES(DROP)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .btn_l_raw   (btn_l_raw),
    .btn_r_raw   (btn_r_raw),
    .btn_drop_raw(btn_drop_raw),
    .auto_en     (auto_en),
    .core_ready  (core_ready),
    .game_over   (game_over),
    .cmd_l       (cmd_l),
    .cmd_r       (cmd_r),
    .cmd_drop    (cmd_drop),
    .drop_src    (drop_src),
    .busy        (busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model. Raw samples are kept as a history; a button's accepted
  // level changes once its synchronized value (raw two edges back) has held
  // the same differing value for the last DB samples.
  bit [2:0] rawh[$];
  bit [2:0] m_stable, m_rise, m_pend;
  bit       m_auto, m_src;
  int       m_timer;
  int       m_mode;   // 0 idle, 1 gap, 2 wait-busy, 3 wait-ready
  int       m_cmd;    // 0 none, 1 left, 2 right, 3 drop

  function automatic void model_reset();
    rawh.delete();
    for (int i = 0; i < DB + 1; i++) rawh.push_front(3'b000);
    m_stable = '0; m_rise = '0; m_pend = '0;
    m_auto = 1'b0; m_src = 1'b0;
    m_timer = 0; m_mode = 0; m_cmd = 0;
  endfunction

  function automatic void model_step();
    bit [2:0] nstable;
    bit [2:0] clr;
    bit       run, hit, same;
    int       grant;
    nstable = m_stable;
    clr     = '0;
    grant   = 0;
    rawh.push_front({btn_drop_raw, btn_r_raw, btn_l_raw});
    for (int b = 0; b < 3; b++) begin
      same = 1'b1;
      for (int j = 2; j <= DB + 1; j++)
        if (rawh[j][b] != rawh[2][b]) same = 1'b0;
      if (same && (rawh[2][b] != m_stable[b])) nstable[b] = rawh[2][b];
    end
    void'(rawh.pop_back());

    run   = auto_en && core_ready && !game_over && (m_mode == 0);
    hit   = run && (m_timer == DROP - 1);
    m_cmd = 0;
    if (game_over) begin
      m_pend = '0; m_auto = 1'b0; m_mode = 0; m_timer = 0;
    end else begin
      if (m_mode == 0 && core_ready) begin
        if (m_pend[2])      grant = 1;
        else if (m_auto)    grant = 2;
        else if (m_pend[0]) grant = 3;
        else if (m_pend[1]) grant = 4;
      end
      if (grant == 1 || grant == 2) begin
        m_cmd = 3; m_src = (grant == 2); clr = 3'b111; m_mode = 2;
      end else if (grant == 3) begin
        m_cmd = 1; clr = 3'b001; m_mode = 1;
      end else if (grant == 4) begin
        m_cmd = 2; clr = 3'b010; m_mode = 1;
      end else if (m_mode == 1) begin
        m_mode = 0;
      end else if (m_mode == 2 && !core_ready) begin
        m_mode = 3;
      end else if (m_mode == 3 && core_ready) begin
        m_mode = 0;
      end
      m_timer = (!run || hit || grant == 1 || grant == 2) ? 0 : m_timer + 1;
      m_pend  = (m_pend & ~clr) | m_rise;
      m_auto  = (m_auto && !(grant == 1 || grant == 2)) || hit;
    end
    m_rise   = nstable & ~m_stable;
    m_stable = nstable;
  endfunction

  // Inputs are already set for the coming edge; advance to the next negedge.
  task automatic step();
    model_step();
    @(negedge clk);
    check("cmd_l", 32'(cmd_l), 32'(m_cmd == 1));
    check("cmd_r", 32'(cmd_r), 32'(m_cmd == 2));
    check("cmd_drop", 32'(cmd_drop), 32'(m_cmd == 3));
    check("drop_src", 32'(drop_src), 32'(m_src));
    check("busy", 32'(busy), 32'(m_mode != 0));
    check("onehot", 32'($countones({cmd_l, cmd_r, cmd_drop}) <= 1), 32'd1);
  endtask

  task automatic do_reset();
    btn_l_raw = 1'b0; btn_r_raw = 1'b0; btn_drop_raw = 1'b0;
    auto_en = 1'b0; game_over = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    check("rst_cmd_l", 32'(cmd_l), 32'd0);
    check("rst_cmd_r", 32'(cmd_r), 32'd0);
    check("rst_cmd_drop", 32'(cmd_drop), 32'd0);
    check("rst_drop_src", 32'(drop_src), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    int first_l, first_r, first_d, n_l, n_r, n_d, busy_at;
    btn_l_raw = 1'b0; btn_r_raw = 1'b0; btn_drop_raw = 1'b0;
    auto_en = 1'b0; core_ready = 1'b0; game_over = 1'b0; rst = 1'b1;
    @(negedge clk);
    do_reset();

    // Single left press: one pulse, DB+4 cycles after the raw rise.
    core_ready = 1'b1;
    first_l = 0; n_l = 0; n_r = 0; n_d = 0;
    for (int i = 1; i <= 22; i++) begin
      btn_l_raw = (i <= 12);
      step();
      if (cmd_l) begin n_l++; if (first_l == 0) first_l = i; end
      if (cmd_r) n_r++;
      if (cmd_drop) n_d++;
    end
    check("left_latency", first_l, 8);
    check("left_count", n_l, 1);
    check("left_others", n_r + n_d, 0);

    // Glitch shorter than the debounce window.
    do_reset();
    core_ready = 1'b1;
    n_l = 0; n_r = 0; n_d = 0;
    for (int i = 1; i <= 16; i++) begin
      btn_r_raw = (i <= 3);
      step();
      n_r += int'(cmd_r); n_l += int'(cmd_l); n_d += int'(cmd_drop);
    end
    check("glitch_cmd_r", n_r, 0);
    check("glitch_any", n_l + n_d, 0);

    // Left and right together: left, one idle cycle, right.
    do_reset();
    core_ready = 1'b1;
    first_l = 0; first_r = 0; busy_at = 0;
    for (int i = 1; i <= 22; i++) begin
      btn_l_raw = (i <= 12);
      btn_r_raw = (i <= 12);
      step();
      if (cmd_l && first_l == 0) begin first_l = i; busy_at = int'(busy); end
      if (cmd_r && first_r == 0) first_r = i;
    end
    check("simul_left", first_l, 8);
    check("simul_right", first_r, 10);
    check("simul_busy_gap", busy_at, 1);

    // Drop beats a queued left; next command only after ready falls and rises.
    do_reset();
    core_ready = 1'b1;
    first_d = 0; first_r = 0; n_l = 0; n_r = 0; n_d = 0; busy_at = 0;
    for (int i = 1; i <= 46; i++) begin
      btn_l_raw    = (i <= 12);
      btn_drop_raw = (i <= 12);
      btn_r_raw    = (i >= 20 && i <= 31);
      core_ready   = !(i >= 34 && i <= 38);
      step();
      if (cmd_drop) begin n_d++; if (first_d == 0) begin first_d = i; busy_at = int'(drop_src); end end
      if (cmd_r) begin n_r++; if (first_r == 0) first_r = i; end
      n_l += int'(cmd_l);
    end
    check("drop_first", first_d, 8);
    check("drop_src_user", busy_at, 0);
    check("drop_count", n_d, 1);
    check("drop_left_discarded", n_l, 0);
    check("post_drop_right_at", first_r, 40);
    check("post_drop_right_cnt", n_r, 1);

    // Gravity timer: auto drop at cycle 21, then frozen while waiting on the core.
    do_reset();
    core_ready = 1'b1; auto_en = 1'b1;
    first_d = 0; n_d = 0; busy_at = 0;
    for (int i = 1; i <= 60; i++) begin
      step();
      if (cmd_drop) begin n_d++; if (first_d == 0) begin first_d = i; busy_at = int'(drop_src); end end
    end
    check("auto_first", first_d, 21);
    check("auto_src", busy_at, 1);
    check("auto_frozen", n_d, 1);

    // Game over: presses and timer produce nothing, and nothing is left queued.
    do_reset();
    core_ready = 1'b1; auto_en = 1'b1; game_over = 1'b1;
    n_l = 0; n_r = 0; n_d = 0;
    for (int i = 1; i <= 40; i++) begin
      btn_l_raw = (i <= 12); btn_r_raw = (i <= 12); btn_drop_raw = (i <= 12);
      step();
      n_l += int'(cmd_l); n_r += int'(cmd_r); n_d += int'(cmd_drop);
    end
    game_over = 1'b0; auto_en = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      step();
      n_l += int'(cmd_l); n_r += int'(cmd_r); n_d += int'(cmd_drop);
    end
    check("gameover_cmds", n_l + n_r + n_d, 0);

    // Reset while stuck in WAIT_BUSY.
    do_reset();
    core_ready = 1'b1;
    for (int i = 1; i <= 14; i++) begin
      btn_drop_raw = (i <= 12);
      step();
    end
    check("stuck_busy", 32'(busy), 32'd1);
    do_reset();

    // Random traffic against the model.
    core_ready = 1'b1;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 7) == 0)  btn_l_raw    = ~btn_l_raw;
      if ($urandom_range(0, 7) == 0)  btn_r_raw    = ~btn_r_raw;
      if ($urandom_range(0, 11) == 0) btn_drop_raw = ~btn_drop_raw;
      if ($urandom_range(0, 5) == 0)  core_ready   = ~core_ready;
      if ($urandom_range(0, 99) == 0) auto_en      = ~auto_en;
      if (game_over) begin
        if ($urandom_range(0, 9) == 0) game_over = 1'b0;
      end else if ($urandom_range(0, 149) == 0) begin
        game_over = 1'b1;
      end
      if ($urandom_range(0, 599) == 0) do_reset();
      else step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
